// File: rtl/q_sampler.sv
// Settles after each i_ref change, then averages 2**AVG_LOG2 Q samples and presents the truncated mean.
// ready is high only while measured_q was taken at the present i_ref, and it drops one edge after i_ref moves.
module q_sampler #(
  parameter int WIDTH         = 10,
  parameter int SETTLE_CYCLES = 16,
  parameter int AVG_LOG2      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i_ref,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_data,
  output logic [WIDTH-1:0] measured_q,
  output logic             ready,
  output logic             busy
);

  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMP_LAST   = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_e;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]   samp_cnt_q, samp_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   i_ref_q;
  logic [WIDTH-1:0]   meas_q, meas_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic [ACC_W-1:0]   sum;
  logic               change;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
      acc_q        <= '0;
      i_ref_q      <= '0;
      meas_q       <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      acc_q        <= acc_d;
      i_ref_q      <= i_ref;
      meas_q       <= meas_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    acc_d        = acc_q;
    meas_d       = meas_q;
    ready_d      = ready_q;
    sum          = acc_q + ACC_W'(sample_data);
    change       = (i_ref != i_ref_q);

    // en=0 outranks a change; a change outranks a completing sample
    if (!en) begin
      state_d      = IDLE;
      ready_d      = 1'b0;
      settle_cnt_d = '0;
      samp_cnt_d   = '0;
      acc_d        = '0;
    end else if (change && state_q != IDLE) begin
      state_d      = SETTLE;
      ready_d      = 1'b0;
      settle_cnt_d = '0;
      samp_cnt_d   = '0;
      acc_d        = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = SETTLE;
          settle_cnt_d = '0;
          samp_cnt_d   = '0;
          acc_d        = '0;
        end
        SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d      = ACCUM;
            settle_cnt_d = '0;
            samp_cnt_d   = '0;
            acc_d        = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + SET_W'(1);
          end
        end
        ACCUM: begin
          if (sample_valid) begin
            acc_d      = sum;
            samp_cnt_d = samp_cnt_q + CNT_W'(1);
            if (samp_cnt_q == SAMP_LAST) begin
              state_d = DONE;
              meas_d  = WIDTH'(sum >> AVG_LOG2);
              ready_d = 1'b1;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == SETTLE) || (state_d == ACCUM);
  end

  assign measured_q = meas_q;
  assign ready      = ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_q_sampler.sv
// Table-driven measurement windows plus hand sequences for collision, mid-window reset and disable.
// Expected means are queued when the final sample is driven and popped on each rising ready.
module tb_q_sampler;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [9:0] i_ref;
  logic       sample_valid;
  logic [9:0] sample_data;
  logic [9:0] measured_q;
  logic       ready;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  logic [9:0] sb_q [$];
  logic       ready_prev = 1'b0;

  always #5 clk = ~clk;

  q_sampler #(.WIDTH(10), .SETTLE_CYCLES(16), .AVG_LOG2(3)) dut (
    .clk(clk), .rst(rst), .en(en), .i_ref(i_ref),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .measured_q(measured_q), .ready(ready), .busy(busy)
  );

  typedef struct {
    logic [9:0] iref;
    logic [9:0] smp [8];
    logic [9:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard: every rising ready must match the oldest queued mean
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_ready actual=%0d expected=none", measured_q);
      end else begin
        logic [9:0] e;
        e = sb_q.pop_front();
        if (measured_q !== e) begin
          failures++;
          $display("FAIL sb_measured_q actual=%0d expected=%0d", measured_q, e);
        end
      end
    end
    ready_prev = ready;
  end

  task automatic change_ref(input logic [9:0] r, input logic [9:0] hold);
    i_ref = r;
    tick();
    chk("ready_drop_on_change", ready, 0);
    chk("busy_on_change", busy, 1);
    chk("meas_hold_on_change", measured_q, hold);
  endtask

  // Called one edge into SETTLE; returns just after the edge that enters ACCUM
  task automatic settle(input bit probe);
    repeat (15) tick();
    if (probe) begin
      sample_valid = 1'b1;
      sample_data  = 10'd999;
    end
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic run_samples(input logic [9:0] s [8], input logic [9:0] e, input bit gap);
    for (int k = 0; k < 8; k++) begin
      sample_valid = 1'b1;
      sample_data  = s[k];
      if (k == 7) sb_q.push_back(e);
      tick();
      if (k == 6) chk("ready_before_last", ready, 0);
      if (gap && k == 3) begin
        sample_valid = 1'b0;
        tick();
      end
    end
    sample_valid = 1'b0;
    chk("ready_on_last", ready, 1);
    chk("busy_in_done", busy, 0);
    chk("meas_on_last", measured_q, e);
  endtask

  initial begin
    vec_t       vecs [6];
    logic [9:0] tmp [8];
    logic [9:0] prev;

    vecs[0] = '{10'd1023, '{8{10'd110}}, 10'd110};
    vecs[1] = '{10'd511,  '{8{10'd40}},  10'd40};
    vecs[2] = '{10'd300,  '{10'd100, 10'd101, 10'd102, 10'd103, 10'd104, 10'd105, 10'd106, 10'd107}, 10'd103};
    vecs[3] = '{10'd800,  '{8{10'd1023}}, 10'd1023};
    vecs[4] = '{10'd5,    '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7}, 10'd3};
    vecs[5] = '{10'd6,    '{10'd1000, 10'd0, 10'd1000, 10'd0, 10'd1000, 10'd0, 10'd1000, 10'd7}, 10'd500};

    rst = 1'b0; en = 1'b0; i_ref = '0; sample_valid = 1'b0; sample_data = '0;
    tick();
    tick();
    chk("reset_meas", measured_q, 0);
    chk("reset_ready", ready, 0);
    chk("reset_busy", busy, 0);

    prev = '0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        rst = 1'b1; en = 1'b1; i_ref = vecs[0].iref;
        tick();
        chk("first_settle_busy", busy, 1);
        chk("first_settle_ready", ready, 0);
      end else begin
        change_ref(vecs[i].iref, prev);
      end
      settle(1'b1);
      run_samples(vecs[i].smp, vecs[i].exp, i[0]);
      sample_valid = 1'b1; sample_data = 10'd999;
      tick();
      tick();
      sample_valid = 1'b0;
      tick();
      chk("done_ignores_meas", measured_q, vecs[i].exp);
      chk("done_ignores_ready", ready, 1);
      prev = vecs[i].exp;
    end

    // i_ref change on the same edge as the 8th sample
    change_ref(10'd77, 10'd500);
    settle(1'b0);
    for (int k = 0; k < 7; k++) begin
      sample_valid = 1'b1; sample_data = 10'd200;
      tick();
    end
    sample_valid = 1'b1; sample_data = 10'd200; i_ref = 10'd78;
    tick();
    sample_valid = 1'b0;
    chk("collide_ready", ready, 0);
    chk("collide_busy", busy, 1);
    chk("collide_meas", measured_q, 500);
    settle(1'b1);
    foreach (tmp[k]) tmp[k] = 10'd60;
    run_samples(tmp, 10'd60, 1'b0);

    // Asynchronous reset four samples into a window
    change_ref(10'd90, 10'd60);
    settle(1'b0);
    for (int k = 0; k < 4; k++) begin
      sample_valid = 1'b1; sample_data = 10'd300;
      tick();
    end
    sample_valid = 1'b0;
    chk("accum_busy", busy, 1);
    rst = 1'b0;
    #2;
    chk("async_rst_meas", measured_q, 0);
    chk("async_rst_ready", ready, 0);
    chk("async_rst_busy", busy, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_busy", busy, 1);
    chk("post_rst_ready", ready, 0);
    settle(1'b1);
    foreach (tmp[k]) tmp[k] = 10'd250;
    run_samples(tmp, 10'd250, 1'b1);

    // Disable while DONE
    en = 1'b0;
    tick();
    chk("dis_ready", ready, 0);
    chk("dis_busy", busy, 0);
    chk("dis_meas_hold", measured_q, 250);
    sample_valid = 1'b1; sample_data = 10'd999;
    tick();
    tick();
    sample_valid = 1'b0;
    chk("idle_ready", ready, 0);
    en = 1'b1;
    tick();
    chk("reenable_busy", busy, 1);
    settle(1'b0);
    foreach (tmp[k]) tmp[k] = 10'd5;
    run_samples(tmp, 10'd5, 1'b0);

    tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/q_sampler.md
Name: q_sampler

Overview:
- Sits directly upstream of the bisection current controller and produces its `measured_q` and `ready` inputs.
- Watches the controller's `i_ref` output. On every change it waits a fixed settling time for the analog loop to respond.
- It then averages 2**AVG_LOG2 raw Q samples from the measurement front end and presents the truncated mean with `ready` high.
- `ready` drops the moment `i_ref` moves again, so the controller never evaluates a stale or partial measurement.

Parameters:
- WIDTH, 10: width of `i_ref`, sample data and `measured_q`.
- SETTLE_CYCLES, 16: clock cycles to wait after an `i_ref` change before accepting samples; must be >= 1.
- AVG_LOG2, 3: log2 of the number of samples averaged per measurement (8 by default); range 0..6.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- en  input  1  measurement enable; low forces IDLE.
- i_ref  input  WIDTH  current reference from the bisection controller; monitored for changes.
- sample_valid  input  1  one-cycle strobe: `sample_data` is valid this cycle.
- sample_data  input  WIDTH  raw Q sample from the front end, unsigned.
- measured_q  output  WIDTH  averaged Q for the current `i_ref`, unsigned.
- ready  output  1  high while `measured_q` corresponds to the present `i_ref`.
- busy  output  1  high in SETTLE or ACCUM.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, `measured_q`=0, `ready`=0, `busy`=0.
  - accumulator=0, sample counter=0, settle counter=0, `i_ref_q` (registered copy of `i_ref`)=0.
- States: IDLE, SETTLE, ACCUM, DONE.
- `i_ref_q` <= `i_ref` every cycle. A change is flagged when `i_ref` != `i_ref_q`; the flag is combinational from the registered copy.
- Transitions:
  - IDLE -> SETTLE when en=1. This covers the first cycle after reset release with en=1, so a first measurement always occurs.
  - SETTLE: settle counter counts from 0. After SETTLE_CYCLES cycles in SETTLE -> ACCUM, with accumulator and sample counter cleared.
  - ACCUM: on sample_valid, accumulator += `sample_data` and sample counter += 1. Samples arriving in SETTLE, DONE or IDLE are ignored.
  - ACCUM -> DONE on the cycle the 2**AVG_LOG2-th sample is accepted. In that same edge, `measured_q` <= (accumulator + `sample_data`) >> AVG_LOG2 (truncating), and `ready` <= 1.
  - DONE: hold `measured_q` and `ready` until a change is flagged or en=0.
  - Change flagged in SETTLE, ACCUM or DONE -> SETTLE. Settle counter, accumulator and sample counter are cleared, `ready` <= 0, and `measured_q` holds its old value.
  - en=0 in any state -> IDLE on the next edge, with `ready` <= 0 and counters cleared.
- Width rules:
  - Accumulator is WIDTH+AVG_LOG2 bits, so it never overflows.
  - Settle counter is clog2(SETTLE_CYCLES+1) bits.
  - Sample counter is AVG_LOG2+1 bits.
- Latency:
  - `i_ref` changes at edge k. `ready` falls at edge k+1 (the change is flagged during cycle k..k+1).
  - The first sample can be accepted SETTLE_CYCLES cycles after entering SETTLE.
  - `ready` rises on the edge that accepts the final sample.
- Simultaneous events:
  - Change flag together with the final sample valid: the change wins, the sample is discarded, `ready` stays 0, and the state goes to SETTLE.
  - en=0 has priority over the change flag.
  - Change flag in IDLE is ignored.
- `busy` = (state==SETTLE) or (state==ACCUM), registered with the state.
- Reset asserted mid-ACCUM: all state clears immediately (asynchronously). After release the block restarts from IDLE.
- AVG_LOG2=0: a single sample goes straight through, and `measured_q` equals that sample.

Test Plan:
- Reset then en=1, `i_ref`=1023 constant, 8 samples of 110 after settle -> `ready` rises on the 8th accepted sample, `measured_q`=110, `busy`=0 in DONE.
- Samples 100,101,...,107 -> sum 828, `measured_q`=103 (truncated); all-1023 samples -> `measured_q`=1023 with no overflow.
- In DONE, change `i_ref` 1023->511 -> `ready`=0 the next cycle, `measured_q` holds the old value, and no sample is accepted for 16 cycles; new samples of 40 -> `measured_q`=40.
- Change `i_ref` on the same cycle as the 8th sample -> `ready` stays 0, state SETTLE, and a full fresh 8-sample window is required.
- sample_valid strobes during SETTLE and DONE -> ignored; the accumulated result is unaffected (check with distinct value 999).
- Assert rst=0 for one cycle mid-ACCUM (4 samples in) -> outputs 0 immediately; after release with en=1, a full settle plus 8 samples is required before `ready`. en=0 in DONE -> `ready`=0 and state IDLE next cycle.
